// File: rtl/mmio_uart_tx_if.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx_if
// Data-memory side bus between the single-cycle processor and the memory-mapped
// UART transmitter.
//
// Handshake: there is no valid/ready pair. A store is the single-cycle strobe
// mem_write qualified by addr, and it is taken at the rising clk edge where it
// is high. A load is mem_read qualified by addr. read_data and sel are
// combinational and settle in the same cycle.
//
// Signals:
//   mem_write   processor store strobe
//   mem_read    processor load strobe
//   addr        processor byte address
//   write_data  store data (only [7:0] is used for TXDATA)
//   read_data   load data, 0 when the UART is not selected
//   sel         1 when addr hits TXDATA or STATUS
// Modports: master = processor side, slave = UART side.
// -----------------------------------------------------------------------------
interface mmio_uart_tx_if;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        sel;

  modport master (
    output mem_write,
    output mem_read,
    output addr,
    output write_data,
    input  read_data,
    input  sel
  );

  modport slave (
    input  mem_write,
    input  mem_read,
    input  addr,
    input  write_data,
    output read_data,
    output sel
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped UART transmitter on the processor's data-memory port.
// A store to TXDATA (BASE_ADDR) pushes write_data[7:0] into a small FIFO. A
// baud-rate FSM pops bytes and sends them as 8N1 frames, LSB first, on tx.
// STATUS (BASE_ADDR+4) reads combinationally:
//   bit0 full, bit1 empty, bit2 fsm_active, bit3 overflow (sticky),
//   bits[7:4] FIFO count, bit8 parity feature present.
// A store to STATUS clears overflow and never enqueues.
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, a PARITY state sends an even parity bit between the data
//   bits and the stop bit, and STATUS bit8 reads 1.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; clears all state
//   bus        mmio_uart_tx_if.slave (mem_write, mem_read, addr, write_data,
//              read_data, sel)
//   tx         serial line, registered, idle high
//   busy       frame in flight or FIFO non-empty
//   state_dbg  current FSM state encoding
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  mmio_uart_tx_if.slave      bus,
  output logic               tx,
  output logic               busy,
  output logic [2:0]         state_dbg
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  state_t          state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
`ifdef UART_TX_PARITY_EN
  logic            par_bit;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;

  logic            hit_tx;
  logic            hit_st;
  logic            full;
  logic            empty;
  logic            baud_done;
  logic            pop;
  logic            push_req;
  logic            push_ok;
  logic [7:0]      head;
  logic [31:0]     status;
  logic [31:0]     cnt_ext;
  logic            unused_wdata;

  // ---------------------------------------------------------------------------
  // Address decode and load path
  // ---------------------------------------------------------------------------
  assign hit_tx  = (bus.addr == BASE_ADDR);
  assign hit_st  = (bus.addr == (BASE_ADDR + 32'd4));
  assign bus.sel = hit_tx | hit_st;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign cnt_ext = 32'(count);

  always_comb begin
    status    = 32'd0;
    status[0] = full;
    status[1] = empty;
    status[2] = (state != IDLE);
    status[3] = overflow;
    status[7:4] = cnt_ext[3:0];
`ifdef UART_TX_PARITY_EN
    status[8] = 1'b1;
`endif
  end

  // TXDATA reads back as 0; only STATUS returns data.
  assign bus.read_data = (bus.mem_read & hit_st) ? status : 32'd0;

  assign unused_wdata = ^bus.write_data[31:8];

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign baud_done = (baud_cnt == BAUD_LAST);
  // The FSM pops from IDLE, or at the last cycle of STOP for back-to-back frames.
  assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & baud_done));
  assign push_req  = bus.mem_write & hit_tx;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok   = push_req & (~full | pop);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.write_data[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.mem_write & hit_st) begin
        overflow <= 1'b0;
      end else if (push_req & ~push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM. tx is driven from here so it is always a flop output.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shift    <= head;
`ifdef UART_TX_PARITY_EN
            par_bit  <= ^head;
`endif
            tx       <= 1'b0;
            baud_cnt <= '0;
            state    <= START;
          end
        end

        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            bit_idx  <= 3'd0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= par_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              // Next bit is shift[1]; it becomes shift[0] after the shift.
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`endif

        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (!empty) begin
              // Back-to-back: straight into the next start bit, no idle gap.
              shift   <= head;
`ifdef UART_TX_PARITY_EN
              par_bit <= ^head;
`endif
              tx      <= 1'b0;
              state   <= START;
            end else begin
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          baud_cnt <= '0;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE) | ~empty;
  assign state_dbg = state;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME = 44;
  localparam logic [31:0] SX    = 32'h0000_0100;
`else
  localparam int          FRAME = 40;
  localparam logic [31:0] SX    = 32'h0000_0000;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx;
  logic       busy;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .tx        (tx),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // ---------------------------------------------------------------------------
  // Checker and driver tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.mem_write  = 1'b1;
    bus.addr       = a;
    bus.write_data = d;
    step();
    bus.mem_write  = 1'b0;
    bus.addr       = 32'h0;
    bus.write_data = 32'h0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_rd, input logic exp_sel);
    bus.mem_read = 1'b1;
    bus.addr     = a;
    #1;
    chk({tag, "_rd"}, bus.read_data, exp_rd);
    chk({tag, "_sel"}, {31'b0, bus.sel}, {31'b0, exp_sel});
    bus.mem_read = 1'b0;
    bus.addr     = 32'h0;
  endtask

  // Expected tx for frame cycle c (c=1 is the cycle after the popping edge).
  function automatic logic exp_bit(input logic [7:0] b, input int c);
    if (c <= 4) return 1'b0;
    if (c <= 36) return b[(c - 5) / 4];
`ifdef UART_TX_PARITY_EN
    if (c <= 40) return ^b;
`endif
    return 1'b1;
  endfunction

  // Checks frame cycles cur+1..FRAME, one clock per cycle.
  task automatic check_frame(input logic [7:0] b, input int cur, input string tag);
    for (int c = cur + 1; c <= FRAME; c++) begin
      step();
      chk($sformatf("%s_c%0d", tag, c), {31'b0, tx}, {31'b0, exp_bit(b, c)});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.addr       = 32'h0;
    bus.write_data = 32'h0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    load_chk("rst_status", BASE + 32'd4, 32'h0000_0002 | SX, 1'b1);

    // Single byte A5
    store(BASE, 32'h0000_00A5);
    check_frame(8'hA5, 0, "a5");
    chk("a5_busy_last_stop", {31'b0, busy}, 32'd1);
    step();
    chk("a5_busy_fall", {31'b0, busy}, 32'd0);
    chk("a5_tx_idle", {31'b0, tx}, 32'd1);

    // Decode
    load_chk("dec_b8", BASE + 32'd8, 32'h0, 1'b0);
    store(BASE + 32'd1, 32'h0000_00FF);
    step();
    chk("dec_b1_nopush_busy", {31'b0, busy}, 32'd0);
    chk("dec_b1_nopush_tx", {31'b0, tx}, 32'd1);
    load_chk("dec_txdata", BASE, 32'h0, 1'b1);
    load_chk("dec_status", BASE + 32'd4, 32'h0000_0002 | SX, 1'b1);

    // Back-to-back 55 then 0F
    store(BASE, 32'h0000_0055);
    store(BASE, 32'h0000_000F);
    chk("b2b_55_c1", {31'b0, tx}, 32'd0);
    load_chk("b2b_status", BASE + 32'd4, 32'h0000_0014 | SX, 1'b1);
    check_frame(8'h55, 1, "b2b55");
    check_frame(8'h0F, 0, "b2b0f");
    step();
    chk("b2b_busy_fall", {31'b0, busy}, 32'd0);

    // Overflow: six stores, 06 dropped
    for (int i = 1; i <= 6; i++) begin
      store(BASE, 32'(i));
    end
    load_chk("ovf_status", BASE + 32'd4, 32'h0000_004D | SX, 1'b1);
    check_frame(8'h01, 5, "ovf01");
    check_frame(8'h02, 0, "ovf02");
    check_frame(8'h03, 0, "ovf03");
    check_frame(8'h04, 0, "ovf04");
    check_frame(8'h05, 0, "ovf05");
    load_chk("ovf_sticky", BASE + 32'd4, 32'h0000_000E | SX, 1'b1);
    store(BASE + 32'd4, 32'hFFFF_FFFF);
    load_chk("ovf_clear", BASE + 32'd4, 32'h0000_0002 | SX, 1'b1);
    chk("ovf_no_sixth_busy", {31'b0, busy}, 32'd0);
    step();
    chk("ovf_no_sixth_tx", {31'b0, tx}, 32'd1);

`ifdef UART_TX_PARITY_EN
    // Parity: 07 has three ones, parity bit 1, 44-cycle frame
    store(BASE, 32'h0000_0007);
    check_frame(8'h07, 0, "par07");
    step();
    chk("par_busy_fall", {31'b0, busy}, 32'd0);
`endif

    // Reset mid-frame with bytes queued
    store(BASE, 32'h0000_0000);
    store(BASE, 32'h0000_0000);
    store(BASE, 32'h0000_0000);
    for (int i = 0; i < 8; i++) step();
    chk("mid_tx_low", {31'b0, tx}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_tx", {31'b0, tx}, 32'd1);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    step();
    reset = 1'b0;
    step();
    load_chk("mid_rst_status", BASE + 32'd4, 32'h0000_0002 | SX, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("mid_discard_tx%0d", i), {31'b0, tx}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
